// File: rtl/rr_sel_arbiter.sv
// Four-channel capture registers with a registered grant that drives a downstream mux4.
// Define RR_SEL_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.

module rr_sel_chan #(
    parameter int IN_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic [IN_WIDTH-1:0] din_i,
    input  logic                clr_i,
    output logic                pend_o,
    output logic                ack_o,
    output logic [IN_WIDTH-1:0] hold_o
);
    logic                pend_q, pend_d;
    logic                ack_q, ack_d;
    logic [IN_WIDTH-1:0] hold_q, hold_d;

    // A request is only taken while the slot is free, so a clear and a capture
    // can never land on the same edge.
    always_comb begin
        ack_d  = req_i & ~pend_q;
        pend_d = pend_q;
        hold_d = hold_q;
        if (ack_d) begin
            pend_d = 1'b1;
            hold_d = din_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            pend_q <= pend_d;
            ack_q  <= ack_d;
            hold_q <= hold_d;
        end
    end

    assign pend_o = pend_q;
    assign ack_o  = ack_q;
    assign hold_o = hold_q;
endmodule

module rr_sel_arbiter #(
    parameter int IN_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               req,
    input  logic [3:0][IN_WIDTH-1:0] din,
    output logic [3:0]               ack,
    output logic [3:0][IN_WIDTH-1:0] in_bus,
    output logic [1:0]               sel,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] pend;
    logic [3:0] clr;
    logic [1:0] pick;
    logic       gnt_done;

    assign gnt_done = (state_q == PRESENT) && out_ready;
    assign clr      = gnt_done ? (4'b0001 << sel_q) : 4'b0000;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        rr_sel_chan #(.IN_WIDTH(IN_WIDTH)) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .req_i  (req[g]),
            .din_i  (din[g]),
            .clr_i  (clr[g]),
            .pend_o (pend[g]),
            .ack_o  (ack[g]),
            .hold_o (in_bus[g])
        );
    end

`ifdef RR_SEL_FIXED_PRIO_EN
    always_comb begin
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend[k]) pick = 2'(k);
        end
    end
`else
    logic [1:0] lg_q, lg_d;
    logic [1:0] cand;
    logic       found;

    // Search starts just past the last winner; k=4 wraps back to last_grant itself.
    always_comb begin
        pick  = lg_q;
        found = 1'b0;
        cand  = lg_q;
        for (int k = 1; k <= 4; k++) begin
            cand = lg_q + 2'(k);
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign lg_d = gnt_done ? sel_q : lg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lg_q <= 2'd3;
        else        lg_q <= lg_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (|pend) begin
                    state_d = PRESENT;
                    sel_d   = pick;
                end
            end
            PRESENT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = (state_q == PRESENT);
endmodule
